// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcode/funct constants, ALU operation codes (shared with the ALU) and the
// bundle of datapath control strobes.
package multicycle_ctrl_pkg;

   // FSM state codes; the numeric values are visible on the debug port
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_e;

   // Opcodes of the supported instruction subset
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes; 011, 100 and 101 are intentionally unused
   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   // Coarse ALU request from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Datapath control strobes other than the ALU operation
   typedef struct packed {
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic [1:0] pcsrc;
      logic       pcen;
   } ctrl_t;

   // State that DECODE dispatches to for a given opcode
   function automatic state_e dispatch_state(input logic [5:0] op);
      state_e nxt;
      case (op)
         OP_LW, OP_SW: nxt = S_MEMADR;
         OP_RTYPE:     nxt = S_RTYPEEX;
         OP_BEQ:       nxt = S_BEQEX;
         OP_ADDI:      nxt = S_ADDIEX;
         OP_J:         nxt = S_JEX;
         default:      nxt = S_FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type funct
// field into a concrete ALU operation code.
module alu_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] aluop,
   output logic [2:0] aluc
);

   // Map aluop/funct to an ALU code; anything unrecognised falls back to ADD
   always_comb begin
      aluc = ALUC_ADD;
      case (aluop)
         ALUOP_ADD: aluc = ALUC_ADD;
         ALUOP_SUB: aluc = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  aluc = ALUC_ADD;
               FN_SUB:  aluc = ALUC_SUB;
               FN_AND:  aluc = ALUC_AND;
               FN_OR:   aluc = ALUC_OR;
               FN_SLT:  aluc = ALUC_SLT;
               default: aluc = ALUC_ADD;
            endcase
         end
         default: aluc = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit (lw, sw, R-type, beq, addi, j).
// Moore FSM; the only input-dependent outputs are aluc in RTYPEEX (funct)
// and pcen in BEQEX (zero). Reset is synchronous and active-low; while it is
// asserted the write strobes are forced low so nothing architectural changes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] aluc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [3:0] state
);

   // Held as a plain 4-bit vector so unused codes 12-15 are representable
   logic [3:0] state_q;
   logic [3:0] state_d;

   ctrl_t      ctrl_raw_s;
   ctrl_t      ctrl_s;
   logic [1:0] aluop_s;
   logic       alu_en_s;
   logic [2:0] dec_aluc_s;

   // State register with synchronous active-low reset to FETCH
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unused codes recover to FETCH
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE:  state_d = dispatch_state(op);
         S_MEMADR: begin
            if (op == OP_LW) begin
               state_d = S_MEMRD;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_MEMRD:   state_d = S_MEMWB;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_MEMWB,
         S_MEMWR,
         S_RTYPEWB,
         S_BEQEX,
         S_ADDIWB,
         S_JEX:     state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // Per-state control strobes; anything not set for a state stays 0
   always_comb begin
      ctrl_raw_s = '0;
      aluop_s    = ALUOP_ADD;
      alu_en_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctrl_raw_s.alusrcb = 2'b01;
            ctrl_raw_s.irwrite = 1'b1;
            ctrl_raw_s.pcen    = 1'b1;
            ctrl_raw_s.pcsrc   = 2'b00;
            alu_en_s           = 1'b1;
         end
         S_DECODE: begin
            ctrl_raw_s.alusrcb = 2'b11;
            alu_en_s           = 1'b1;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl_raw_s.alusrca = 1'b1;
            ctrl_raw_s.alusrcb = 2'b10;
            alu_en_s           = 1'b1;
         end
         S_MEMRD: begin
            ctrl_raw_s.iord = 1'b1;
         end
         S_MEMWB: begin
            ctrl_raw_s.memtoreg = 1'b1;
            ctrl_raw_s.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl_raw_s.iord     = 1'b1;
            ctrl_raw_s.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            ctrl_raw_s.alusrca = 1'b1;
            ctrl_raw_s.alusrcb = 2'b00;
            aluop_s            = ALUOP_FUNCT;
            alu_en_s           = 1'b1;
         end
         S_RTYPEWB: begin
            ctrl_raw_s.regdst   = 1'b1;
            ctrl_raw_s.regwrite = 1'b1;
         end
         S_BEQEX: begin
            ctrl_raw_s.alusrca = 1'b1;
            ctrl_raw_s.alusrcb = 2'b00;
            ctrl_raw_s.pcsrc   = 2'b01;
            ctrl_raw_s.pcen    = zero;
            aluop_s            = ALUOP_SUB;
            alu_en_s           = 1'b1;
         end
         S_ADDIWB: begin
            ctrl_raw_s.regwrite = 1'b1;
         end
         S_JEX: begin
            ctrl_raw_s.pcsrc = 2'b10;
            ctrl_raw_s.pcen  = 1'b1;
         end
         default: begin
            ctrl_raw_s = '0;
         end
      endcase
   end

   // While reset is held, suppress every strobe that commits state
   always_comb begin
      ctrl_s = ctrl_raw_s;
      if (!rst_n) begin
         ctrl_s.pcen     = 1'b0;
         ctrl_s.irwrite  = 1'b0;
         ctrl_s.regwrite = 1'b0;
         ctrl_s.memwrite = 1'b0;
      end else begin
         ctrl_s = ctrl_raw_s;
      end
   end

   alu_dec u_alu_dec (
      .funct (funct),
      .aluop (aluop_s),
      .aluc  (dec_aluc_s)
   );

   // States that do not use the ALU drive a zero operation code
   assign aluc     = alu_en_s ? dec_aluc_s : 3'b000;
   assign alusrca  = ctrl_s.alusrca;
   assign alusrcb  = ctrl_s.alusrcb;
   assign iord     = ctrl_s.iord;
   assign memwrite = ctrl_s.memwrite;
   assign irwrite  = ctrl_s.irwrite;
   assign regdst   = ctrl_s.regdst;
   assign memtoreg = ctrl_s.memtoreg;
   assign regwrite = ctrl_s.regwrite;
   assign pcsrc    = ctrl_s.pcsrc;
   assign pcen     = ctrl_s.pcen;
   assign state    = state_q;

endmodule
